// File: rtl/dc_peak_detector_if.sv
// Metric-sample stream between the DC metric register stage and the peak detector.
// tdata carries {R[63:32], P[31:0]}; tready is driven by the detector.
interface dc_peak_detector_if;
   logic [63:0] tdata;
   logic        tvalid;
   logic        tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/dc_peak_detector.sv
// Frame-start detector: thresholded P/R plateau qualification with peak localisation.
// Optional macro PEAK_TRACK_EN keeps tracking the argmax of P until the plateau ends.
module dc_peak_detector #(
   parameter int PLATEAU_LEN = 16,
   parameter int HOLDOFF_LEN = 160
) (
   input  logic              clk,
   input  logic              rst_n,
   dc_peak_detector_if.slave s_axis,
   input  logic [7:0]        thr,
   output logic              det_valid,
   output logic [15:0]       det_index,
   output logic [31:0]       det_peak,
   output logic              busy
);
   localparam logic [7:0]  PLAT_L = 8'(PLATEAU_LEN);
   localparam logic [15:0] HOLD_L = 16'(HOLDOFF_LEN);

`ifdef PEAK_TRACK_EN
   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_PLATEAU = 2'd1,
      ST_TRACK   = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_PLATEAU = 2'd1,
      ST_HOLDOFF = 2'd3
   } state_t;
`endif

   state_t      state_r;
   state_t      state_nxt_s;
   state_t      after_det_s;
   logic [15:0] idx_r;
   logic [7:0]  run_r;
   logic [7:0]  run_nxt_s;
   logic [15:0] hold_r;
   logic [15:0] hold_nxt_s;
   logic        det_valid_r;
   logic [15:0] det_index_r;
   logic [31:0] det_peak_r;
   logic        busy_r;
   logic        fire_s;
   logic [15:0] fire_idx_s;
   logic [31:0] fire_p_s;
   logic        accept_s;
   logic        above_s;
   logic [31:0] p_s;
   logic [31:0] r_s;
   logic [39:0] lhs_s;
   logic [39:0] rhs_s;

`ifdef PEAK_TRACK_EN
   logic [31:0] peak_p_r;
   logic [31:0] peak_p_nxt_s;
   logic [15:0] peak_idx_r;
   logic [15:0] peak_idx_nxt_s;
   logic        upd_s;

   // Strict compare so equal maxima keep the earliest index.
   assign upd_s = (p_s > peak_p_r);
`endif

   // The block never stalls; it is only unready while held in reset.
   assign s_axis.tready = rst_n;
   assign accept_s      = s_axis.tvalid & rst_n;
   assign p_s           = s_axis.tdata[31:0];
   assign r_s           = s_axis.tdata[63:32];
   assign lhs_s         = {p_s, 8'h00};
   assign rhs_s         = {8'h00, r_s} * {32'h0000_0000, thr};
   assign above_s       = (lhs_s >= rhs_s);

   // Destination state after a detection; a zero holdoff skips HOLDOFF.
   always_comb begin
      if (HOLD_L == 16'd0) begin
         after_det_s = ST_SEARCH;
      end else begin
         after_det_s = ST_HOLDOFF;
      end
   end

   // Next-state, run/holdoff counters, peak update and detection strobe.
   always_comb begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
      hold_nxt_s  = hold_r;
      fire_s      = 1'b0;
      fire_idx_s  = idx_r;
      fire_p_s    = p_s;
`ifdef PEAK_TRACK_EN
      peak_p_nxt_s   = peak_p_r;
      peak_idx_nxt_s = peak_idx_r;
`endif
      if (accept_s) begin
         case (state_r)
            ST_SEARCH: begin
               if (above_s) begin
                  run_nxt_s = 8'd1;
`ifdef PEAK_TRACK_EN
                  peak_p_nxt_s   = p_s;
                  peak_idx_nxt_s = idx_r;
                  if (PLAT_L == 8'd1) begin
                     state_nxt_s = ST_TRACK;
                  end else begin
                     state_nxt_s = ST_PLATEAU;
                  end
`else
                  if (PLAT_L == 8'd1) begin
                     fire_s      = 1'b1;
                     run_nxt_s   = 8'd0;
                     hold_nxt_s  = 16'd0;
                     state_nxt_s = after_det_s;
                  end else begin
                     state_nxt_s = ST_PLATEAU;
                  end
`endif
               end else begin
                  run_nxt_s = 8'd0;
               end
            end
            ST_PLATEAU: begin
               if (above_s) begin
                  run_nxt_s = run_r + 8'd1;
`ifdef PEAK_TRACK_EN
                  if (upd_s) begin
                     peak_p_nxt_s   = p_s;
                     peak_idx_nxt_s = idx_r;
                  end else begin
                     peak_p_nxt_s   = peak_p_r;
                  end
                  if ((run_r + 8'd1) == PLAT_L) begin
                     state_nxt_s = ST_TRACK;
                  end else begin
                     state_nxt_s = ST_PLATEAU;
                  end
`else
                  if ((run_r + 8'd1) == PLAT_L) begin
                     fire_s      = 1'b1;
                     run_nxt_s   = 8'd0;
                     hold_nxt_s  = 16'd0;
                     state_nxt_s = after_det_s;
                  end else begin
                     state_nxt_s = ST_PLATEAU;
                  end
`endif
               end else begin
                  run_nxt_s   = 8'd0;
                  state_nxt_s = ST_SEARCH;
               end
            end
`ifdef PEAK_TRACK_EN
            ST_TRACK: begin
               if (above_s) begin
                  if (run_r == 8'hFF) begin
                     run_nxt_s = run_r;
                  end else begin
                     run_nxt_s = run_r + 8'd1;
                  end
                  if (upd_s) begin
                     peak_p_nxt_s   = p_s;
                     peak_idx_nxt_s = idx_r;
                  end else begin
                     peak_p_nxt_s   = peak_p_r;
                  end
               end else begin
                  fire_s      = 1'b1;
                  fire_idx_s  = peak_idx_r;
                  fire_p_s    = peak_p_r;
                  run_nxt_s   = 8'd0;
                  hold_nxt_s  = 16'd0;
                  state_nxt_s = after_det_s;
               end
            end
`endif
            ST_HOLDOFF: begin
               if ((hold_r + 16'd1) == HOLD_L) begin
                  hold_nxt_s  = 16'd0;
                  state_nxt_s = ST_SEARCH;
               end else begin
                  hold_nxt_s  = hold_r + 16'd1;
               end
            end
            default: begin
               run_nxt_s   = 8'd0;
               hold_nxt_s  = 16'd0;
               state_nxt_s = ST_SEARCH;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_SEARCH;
         idx_r       <= 16'd0;
         run_r       <= 8'd0;
         hold_r      <= 16'd0;
         det_valid_r <= 1'b0;
         det_index_r <= 16'd0;
         det_peak_r  <= 32'd0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         run_r       <= run_nxt_s;
         hold_r      <= hold_nxt_s;
         det_valid_r <= fire_s;
         busy_r      <= (state_nxt_s != ST_SEARCH);
         if (accept_s) begin
            idx_r <= idx_r + 16'd1;
         end
         if (fire_s) begin
            det_index_r <= fire_idx_s;
            det_peak_r  <= fire_p_s;
         end
      end
   end

`ifdef PEAK_TRACK_EN
   // Running argmax of P across the plateau.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         peak_p_r   <= 32'd0;
         peak_idx_r <= 16'd0;
      end else begin
         peak_p_r   <= peak_p_nxt_s;
         peak_idx_r <= peak_idx_nxt_s;
      end
   end
`endif

   assign det_valid = det_valid_r;
   assign det_index = det_index_r;
   assign det_peak  = det_peak_r;
   assign busy      = busy_r;
endmodule

// File: doc/dc_peak_detector.md
# dc_peak_detector

Frame-start detector consuming the delay-and-correlate metric pair (correlation P, energy R) from the synchronizer's metric registers. Normalises P against a programmable fraction of R, requires a plateau of consecutive above-threshold samples, locates the metric peak within the plateau, and emits a one-cycle detection pulse with the peak's sample index. Sits between the DC metric register stage and the frame-timing/FFT-window controller in the receive path.

## Interface
- PLATEAU_LEN, 16: consecutive above-threshold samples needed to qualify a plateau (1..255).
- HOLDOFF_LEN, 160: samples ignored after a detection (0..65535).
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_axis_tdata  in  64  {R[63:32], P[31:0]}, both unsigned
- s_axis_tvalid  in  1  metric sample valid
- s_axis_tready  out  1  sample accept
- thr  in  8  threshold, unsigned Q0.8 (threshold = thr/256); sampled every accepted beat
- det_valid  out  1  one-cycle detection pulse
- det_index  out  16  sample index of reported peak
- det_peak  out  32  P value at reported peak
- busy  out  1  high in any state except SEARCH

## Operation
- Accept = s_axis_tvalid & s_axis_tready. s_axis_tready is 0 during reset and 1 in all other cycles; the block never stalls.
- Sample counter idx (16 bit) increments on every accept and wraps 0xFFFF -> 0x0000. The first sample accepted after reset has index 0.
- Above-threshold test: {P, 8'b0} >= R*thr, computed in 40 bits, unsigned, no rounding. thr=0 makes every sample above-threshold. P=R=0 is above-threshold.
- FSM. All transitions occur only on an accept.
  - SEARCH: on an above sample, load run=1 and peak={P, idx}. Go to PLATEAU, or directly to TRACK if PLATEAU_LEN=1.
  - PLATEAU: on an above sample, run++ and update peak if P > peak_P (strict, so ties keep the earlier index). When run reaches PLATEAU_LEN, go to TRACK. On a below sample, return to SEARCH with no output.
  - TRACK: on an above sample, update peak as in PLATEAU. On a below sample, emit detection of the stored peak and go to HOLDOFF, or to SEARCH if HOLDOFF_LEN=0.
  - HOLDOFF: count accepts, above-threshold or not. After HOLDOFF_LEN accepts, return to SEARCH.
- In TRACK, run saturates at 255. A plateau of any length ends only on a below sample; there is no timeout.
- Reset mid-operation returns the FSM to SEARCH, clears idx, run, peak and the holdoff count, and discards any pending detection.
- Changing thr mid-plateau takes effect on the next accepted sample.

## Timing
- Reset values: s_axis_tready=0, det_valid=0, det_index=0, det_peak=0, busy=0.
- Latency: det_valid is high in the cycle after the accept of the first below-threshold sample that ends TRACK, for exactly one cycle.
- det_index and det_peak are registered and change only when det_valid rises. They hold their value until the next detection.
- busy is registered and reflects the state after the current accept.
- Gaps in s_axis_tvalid freeze all state. Gaps do not advance idx or the holdoff count.

## Configuration
- PEAK_TRACK_EN defined: peak tracking as described above; det_index and det_peak report the argmax of P over the whole plateau.
- PEAK_TRACK_EN undefined: TRACK is removed.
  - Detection fires in the cycle after the accept on which run reaches PLATEAU_LEN.
  - det_index and det_peak report that sample's idx and P.
  - The FSM then enters HOLDOFF.
  - The comparator is still required; the peak compare logic is removed.

## Test plan
- Reset with valid high: tready=0 and all outputs 0 while rst_n=0. First accept after release gets idx 0.
- thr=128, R=1000, P=400 on samples 0..9 and P=600 on samples 10..40 with P=900 at 25, P=400 from 41. With PEAK_TRACK_EN: det_valid one cycle after the accept of sample 41, det_index=25, det_peak=900, busy high through holdoff. Without PEAK_TRACK_EN: det_valid one cycle after the accept of sample 25, det_index=25, det_peak=900.
- Short run: 15 above samples then one below (PLATEAU_LEN=16). Required: no det_valid, FSM returns to SEARCH, busy=0.
- Holdoff: a second plateau starting 100 samples after a detection (HOLDOFF_LEN=160) is ignored. The same plateau starting 161 samples after is detected.
- Tie and boundary: equal maximum P at indices 30 and 35 gives det_index=30. P*256 == R*thr counts as above. Random tvalid gaps give results identical to a gap-free run.
- Wrap: idx preloaded near 0xFFFF by 65530 below samples, with the peak landing 3 samples after the wrap. Required: det_index=0x0002. Also assert reset during TRACK: no det_valid, and a clean detection afterwards.
